// File: rtl/multicycle_sequencer_if.sv
// Shared memory port between the multi-cycle sequencer and the memory.
// The sequencer drives the strobes and address select; memory answers with ready.
interface multicycle_sequencer_if;
    logic mem_read;
    logic mem_write;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_read,
        output mem_write,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over one memory port,
// with illegal-opcode and memory-timeout traps and a retired-instruction counter.
module multicycle_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    multicycle_sequencer_if.master mem,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             regwrite,
    output logic [1:0]       wb_sel,
    output logic [2:0]       aluop,
    output logic             alusrc2,
    output logic             lui,
    output logic             instr_done,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BR,
        C_JAL, C_JALR, C_LUI, C_AUIPC
    } cls_e;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_R      = 3'd1;
    localparam logic [2:0] OP_I      = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_STORE  = 3'd4;
    localparam logic [2:0] OP_BRANCH = 3'd5;
    localparam logic [2:0] OP_JUMP   = 3'd6;
    localparam logic [2:0] OP_U      = 3'd7;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e        state_q;
    cls_e          cls_q;
    cls_e          cls_d;
    logic [CW-1:0] wcnt;
    logic          rd, wr, ad;
    logic          tmo;

    always_comb begin
        cls_d = C_NONE;
        case (opcode)
            7'b0110011: cls_d = C_R;
            7'b0010011: cls_d = C_I;
            7'b0000011: cls_d = C_LOAD;
            7'b0100011: cls_d = C_STORE;
            7'b1100011: cls_d = C_BR;
            7'b1101111: cls_d = C_JAL;
            7'b1100111: cls_d = C_JALR;
            7'b0110111: cls_d = C_LUI;
            7'b0010111: cls_d = C_AUIPC;
            default:    cls_d = C_NONE;
        endcase
    end

    // Completion on the same cycle beats the timeout.
    assign tmo = (TIMEOUT > 0) && !mem.mem_ready && (wcnt == WLAST);

    always_comb begin
        rd = 1'b0; wr = 1'b0; ad = 1'b0;
        ir_write = 1'b0; pc_write = 1'b0; pc_sel = 2'b00;
        regwrite = 1'b0; wb_sel = 2'b00; aluop = OP_NOP;
        alusrc2 = 1'b0; lui = 1'b0; instr_done = 1'b0; trap = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                rd = 1'b1;
                ir_write = mem.mem_ready;
                pc_write = mem.mem_ready;
            end
            S_EXEC: begin
                unique case (cls_q)
                    C_R:     aluop = OP_R;
                    C_I:     aluop = OP_I;
                    C_LOAD:  aluop = OP_LOAD;
                    C_STORE: aluop = OP_STORE;
                    C_BR:    aluop = OP_BRANCH;
                    C_JAL,
                    C_JALR:  aluop = OP_JUMP;
                    C_LUI,
                    C_AUIPC: aluop = OP_U;
                    default: aluop = OP_NOP;
                endcase
                alusrc2 = (cls_q == C_I) || (cls_q == C_LOAD) ||
                          (cls_q == C_STORE) || (cls_q == C_LUI) ||
                          (cls_q == C_AUIPC);
                lui = (cls_q == C_LUI);
                if (cls_q == C_BR) begin
                    pc_write   = branch_taken;
                    pc_sel     = 2'b01;
                    instr_done = 1'b1;
                end else if (cls_q == C_JAL) begin
                    pc_write = 1'b1;
                    pc_sel   = 2'b01;
                end else if (cls_q == C_JALR) begin
                    pc_write = 1'b1;
                    pc_sel   = 2'b10;
                end
            end
            S_MEM: begin
                ad = 1'b1;
                rd = (cls_q == C_LOAD);
                wr = (cls_q == C_STORE);
                instr_done = (cls_q == C_STORE) && mem.mem_ready;
            end
            S_WB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                if (cls_q == C_LOAD)
                    wb_sel = 2'b01;
                else if (cls_q == C_JAL || cls_q == C_JALR)
                    wb_sel = 2'b10;
            end
            S_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    assign mem.mem_read  = rd;
    assign mem.mem_write = wr;
    assign mem.iord      = ad;
    assign state         = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cls_q      <= C_NONE;
            wcnt       <= '0;
            trap_cause <= 2'b00;
            instret    <= '0;
        end else begin
            if (instr_done) begin
                instret <= instret + CNT_W'(1);
                state_q <= en ? S_FETCH : S_IDLE;
                wcnt    <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: if (en) begin
                        state_q <= S_FETCH;
                        wcnt    <= '0;
                    end
                    S_FETCH: begin
                        if (mem.mem_ready) begin
                            state_q <= S_DECODE;
                        end else if (tmo) begin
                            state_q    <= S_TRAP;
                            trap_cause <= 2'b10;
                        end else begin
                            wcnt <= wcnt + CW'(1);
                        end
                    end
                    S_DECODE: begin
                        cls_q <= cls_d;
                        if (cls_d == C_NONE) begin
                            state_q    <= S_TRAP;
                            trap_cause <= 2'b01;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        if (cls_q == C_LOAD || cls_q == C_STORE) begin
                            state_q <= S_MEM;
                            wcnt    <= '0;
                        end else begin
                            state_q <= S_WB;
                        end
                    end
                    S_MEM: begin
                        if (mem.mem_ready) begin
                            state_q <= S_WB;
                        end else if (tmo) begin
                            state_q    <= S_TRAP;
                            trap_cause <= 2'b10;
                        end else begin
                            wcnt <= wcnt + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (TIMEOUT=4) with hand-computed expectations.
`timescale 1ns/1ps
module tb_multicycle_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        ir_write, pc_write, regwrite, alusrc2, lui;
    logic        instr_done, trap;
    logic [1:0]  pc_sel, wb_sel, trap_cause;
    logic [2:0]  aluop, state;
    logic [31:0] instret;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_sequencer_if mem_if ();

    multicycle_sequencer #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode),
        .branch_taken(branch_taken), .mem(mem_if.master),
        .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
        .regwrite(regwrite), .wb_sel(wb_sel), .aluop(aluop),
        .alusrc2(alusrc2), .lui(lui), .instr_done(instr_done),
        .trap(trap), .trap_cause(trap_cause), .instret(instret),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_instret", instret, 0);
        chk("rst_trap", 32'(trap), 0);
        chk("rst_cause", 32'(trap_cause), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One WB-ending instruction from IDLE with zero-wait memory.
    task automatic run_wb(input logic [6:0] op, input logic [2:0] e_alu,
                          input logic e_pcw, input logic [1:0] e_pcs,
                          input logic e_src2, input logic e_lui,
                          input logic [1:0] e_wbs);
        en = 1'b1; opcode = op; mem_if.mem_ready = 1'b1;
        tick(); tick(); tick();
        chk("wbx_state", 32'(state), 3);
        chk("wbx_aluop", 32'(aluop), 32'(e_alu));
        chk("wbx_pcw", 32'(pc_write), 32'(e_pcw));
        chk("wbx_pcsel", 32'(pc_sel), 32'(e_pcs));
        chk("wbx_src2", 32'(alusrc2), 32'(e_src2));
        chk("wbx_lui", 32'(lui), 32'(e_lui));
        tick();
        chk("wbx_wb", 32'(state), 5);
        chk("wbx_wbsel", 32'(wb_sel), 32'(e_wbs));
        chk("wbx_done", 32'(instr_done), 1);
        en = 1'b0;
        tick();
        chk("wbx_idle", 32'(state), 0);
    endtask

    initial begin
        en = 1'b0; opcode = 7'd0; branch_taken = 1'b0;
        mem_if.mem_ready = 1'b0;
        #2;
        do_reset();
        chk("rst_mem_read", 32'(mem_if.mem_read), 0);
        chk("rst_aluop", 32'(aluop), 0);

        // R-type, zero wait
        en = 1'b1; opcode = 7'b0110011; mem_if.mem_ready = 1'b1;
        tick();
        chk("r_fetch", 32'(state), 1);
        chk("r_mrd", 32'(mem_if.mem_read), 1);
        chk("r_iord", 32'(mem_if.iord), 0);
        chk("r_irw", 32'(ir_write), 1);
        chk("r_pcw", 32'(pc_write), 1);
        tick();
        chk("r_dec", 32'(state), 2);
        tick();
        chk("r_exec", 32'(state), 3);
        chk("r_aluop", 32'(aluop), 1);
        chk("r_src2", 32'(alusrc2), 0);
        chk("r_done_early", 32'(instr_done), 0);
        tick();
        chk("r_wb", 32'(state), 5);
        chk("r_regw", 32'(regwrite), 1);
        chk("r_wbsel", 32'(wb_sel), 0);
        chk("r_done", 32'(instr_done), 1);

        // LOAD with two wait cycles in MEM
        opcode = 7'b0000011;
        tick();
        chk("ld_fetch", 32'(state), 1);
        chk("ld_instret0", instret, 1);
        tick();
        tick();
        chk("ld_aluop", 32'(aluop), 3);
        chk("ld_src2", 32'(alusrc2), 1);
        mem_if.mem_ready = 1'b0;
        tick();
        chk("ld_mem1", 32'(state), 4);
        chk("ld_mrd", 32'(mem_if.mem_read), 1);
        chk("ld_iord", 32'(mem_if.iord), 1);
        chk("ld_mwr", 32'(mem_if.mem_write), 0);
        tick();
        chk("ld_mem2", 32'(state), 4);
        tick();
        chk("ld_mem3", 32'(state), 4);
        mem_if.mem_ready = 1'b1;
        #1;
        chk("ld_mrd3", 32'(mem_if.mem_read), 1);
        chk("ld_nodone", 32'(instr_done), 0);
        tick();
        chk("ld_wb", 32'(state), 5);
        chk("ld_wbsel", 32'(wb_sel), 1);
        chk("ld_done", 32'(instr_done), 1);
        en = 1'b0;
        tick();
        chk("ld_idle", 32'(state), 0);
        chk("ld_instret", instret, 2);

        // BEQ taken then not taken
        en = 1'b1; opcode = 7'b1100011; branch_taken = 1'b1;
        tick(); tick(); tick();
        chk("bt_exec", 32'(state), 3);
        chk("bt_pcw", 32'(pc_write), 1);
        chk("bt_pcsel", 32'(pc_sel), 1);
        chk("bt_aluop", 32'(aluop), 5);
        chk("bt_done", 32'(instr_done), 1);
        branch_taken = 1'b0;
        tick();
        chk("bn_fetch", 32'(state), 1);
        chk("bn_instret", instret, 3);
        tick(); tick();
        chk("bn_pcw", 32'(pc_write), 0);
        chk("bn_done", 32'(instr_done), 1);
        en = 1'b0;
        tick();
        chk("bn_idle", 32'(state), 0);
        chk("bn_instret2", instret, 4);

        // STORE retires from MEM
        en = 1'b1; opcode = 7'b0100011;
        tick(); tick(); tick();
        chk("st_aluop", 32'(aluop), 4);
        tick();
        chk("st_mem", 32'(state), 4);
        chk("st_mwr", 32'(mem_if.mem_write), 1);
        chk("st_mrd", 32'(mem_if.mem_read), 0);
        chk("st_iord", 32'(mem_if.iord), 1);
        chk("st_done", 32'(instr_done), 1);
        en = 1'b0;
        tick();
        chk("st_idle", 32'(state), 0);
        chk("st_instret", instret, 5);

        run_wb(7'b1101111, 3'd6, 1'b1, 2'b01, 1'b0, 1'b0, 2'b10);
        run_wb(7'b1100111, 3'd6, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10);
        run_wb(7'b0110111, 3'd7, 1'b0, 2'b00, 1'b1, 1'b1, 2'b00);
        run_wb(7'b0010111, 3'd7, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00);
        run_wb(7'b0010011, 3'd2, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00);
        chk("wbx_instret", instret, 10);

        // en dropped mid-instruction
        en = 1'b1; opcode = 7'b0110011; mem_if.mem_ready = 1'b1;
        tick(); tick(); tick();
        en = 1'b0;
        tick();
        chk("ed_done", 32'(instr_done), 1);
        tick();
        chk("ed_idle", 32'(state), 0);
        tick();
        chk("ed_idle2", 32'(state), 0);
        en = 1'b1;
        tick();
        chk("ed_fetch", 32'(state), 1);

        // Ready on the 4th FETCH cycle still completes
        mem_if.mem_ready = 1'b0;
        tick(); tick(); tick();
        chk("tw_fetch4", 32'(state), 1);
        mem_if.mem_ready = 1'b1;
        #1;
        chk("tw_irw", 32'(ir_write), 1);
        tick();
        chk("tw_dec", 32'(state), 2);
        tick(); tick();
        en = 1'b0;
        tick();
        chk("tw_instret", instret, 12);

        // FETCH timeout trap
        en = 1'b1; mem_if.mem_ready = 1'b0;
        tick(); tick(); tick(); tick();
        chk("to_fetch4", 32'(state), 1);
        tick();
        chk("to_state", 32'(state), 6);
        chk("to_trap", 32'(trap), 1);
        chk("to_cause", 32'(trap_cause), 2);
        chk("to_mrd", 32'(mem_if.mem_read), 0);
        chk("to_instret", instret, 12);
        do_reset();

        // Illegal opcode trap is terminal
        en = 1'b1; opcode = 7'b0000000; mem_if.mem_ready = 1'b1;
        tick(); tick(); tick();
        chk("il_state", 32'(state), 6);
        chk("il_cause", 32'(trap_cause), 1);
        chk("il_instret", instret, 0);
        en = 1'b0;
        tick();
        chk("il_hold0", 32'(state), 6);
        en = 1'b1;
        tick();
        chk("il_hold1", 32'(state), 6);
        do_reset();

        // Reset mid-instruction aborts without retiring
        en = 1'b1; opcode = 7'b0110011;
        tick(); tick(); tick(); tick(); tick();
        chk("ab_instret1", instret, 1);
        tick(); tick();
        chk("ab_exec", 32'(state), 3);
        rst_n = 1'b0;
        #1;
        chk("ab_state", 32'(state), 0);
        chk("ab_instret", instret, 0);
        chk("ab_done", 32'(instr_done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
FSM controller that sequences the RV32I datapath in multi-cycle mode over a single shared memory port.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and asserts per-state strobes.
- Waits on a memory ready handshake and traps on illegal opcodes or memory timeout.
- Counts retired instructions.
- Sits between the instruction register / memory interface and the register file, ALU and PC logic.

Parameters:
TIMEOUT, 15, max cycles waiting for mem_ready in FETCH/MEM before bus-error trap; 0 disables the timeout.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  run enable; sampled only at instruction boundaries
opcode  input  7  instr[6:0] from instruction register
branch_taken  input  1  ALU compare result, valid in EXEC
mem_ready  input  1  memory handshake; access completes in any cycle where it is high during FETCH/MEM
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
iord  output  1  memory address select: 0 = PC, 1 = ALU result
ir_write  output  1  load instruction register
pc_write  output  1  update PC
pc_sel  output  2  00 PC+4, 01 ALU target (branch/JAL), 10 JALR target
regwrite  output  1  register-file write enable
wb_sel  output  2  00 ALU, 01 memory data, 10 saved PC+4
aluop  output  3  shared ALU-op encoding (NOP, R_TYPE, I_TYPE, LOAD, STORE, BRANCH, JUMP, U_TYPE)
alusrc2  output  1  ALU operand B = immediate
lui  output  1  zero ALU operand A (LUI)
instr_done  output  1  one-cycle pulse on retirement
trap  output  1  sticky trap flag
trap_cause  output  2  01 illegal opcode, 10 memory timeout
instret  output  CNT_W  retired-instruction count
state  output  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; instret=0; trap=0; trap_cause=00; wait counter=0; latched class=none.
  - All strobes 0; aluop=NOP; pc_sel=00; wb_sel=00.
- Outputs are combinational from the state register and the latched instruction class. Every strobe is 0 unless listed for the current state.
- IDLE: all strobes 0. en=1 -> FETCH.
- FETCH:
  - Drives mem_read=1, iord=0.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_sel=00, -> DECODE.
- DECODE:
  - Latch class from opcode: 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BR, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
  - Any other opcode -> TRAP with cause 01.
  - Otherwise -> EXEC.
- EXEC:
  - Drives aluop per class. alusrc2=1 for I/LOAD/STORE/LUI/AUIPC. lui=1 for LUI only.
  - BR: pc_write=branch_taken, pc_sel=01, retire.
  - JAL: pc_write=1, pc_sel=01, -> WB.
  - JALR: pc_write=1, pc_sel=10, -> WB.
  - LOAD/STORE: -> MEM.
  - R/I/LUI/AUIPC: -> WB.
- MEM:
  - Drives iord=1, with mem_read=1 (LOAD) or mem_write=1 (STORE). Strobes are held until the mem_ready cycle.
  - On mem_ready: LOAD -> WB; STORE retires.
- WB:
  - regwrite=1. wb_sel=01 for LOAD, 10 for JAL/JALR, else 00. Then retire.
- Retire (same cycle as the final state):
  - instr_done=1; instret increments, wrapping at 2^CNT_W.
  - Next state is FETCH if en=1, else IDLE. en is ignored mid-instruction.
- Memory timeout:
  - Wait counter clears on entry to FETCH/MEM and increments each cycle mem_ready=0.
  - If mem_ready=0 while the counter equals TIMEOUT-1 (TIMEOUT>0): -> TRAP, cause 10, and strobes drop the next cycle.
  - mem_ready=1 on that same cycle completes normally; completion wins over timeout.
- TRAP: trap=1, all strobes 0, terminal until rst_n; en has no effect.
- Latency with zero-wait memory: BR 3 cycles; R/I/U/JAL/JALR 4; STORE 4; LOAD 5. Each wait cycle adds 1.
- Reset asserted mid-instruction aborts immediately: no retire, instret is unchanged except cleared to 0.

Test Plan:
- Reset, then en=1, opcode=0110011, mem_ready=1 -> states 1,2,3,5; regwrite=1 in WB; instr_done pulses on cycle 4; instret=1.
- LOAD (0000011) with mem_ready low 2 cycles in MEM -> MEM lasts 3 cycles with mem_read=1, iord=1; WB has wb_sel=01; total 7 cycles.
- BEQ (1100011): branch_taken=1 -> pc_write=1, pc_sel=01 in EXEC, retire after 3 cycles; branch_taken=0 -> pc_write=0, still retires.
- Opcode 0000000 -> TRAP, trap_cause=01, instret unchanged; en toggling keeps state=6 until rst_n low.
- TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP on the 5th cycle, cause 10. A second run with mem_ready=1 exactly on the 4th wait cycle -> normal DECODE.
- en dropped during EXEC of an R-type -> instruction still completes, instr_done=1, then state=IDLE; en=1 again -> FETCH.
